// File: rtl/seq_array_divider.sv
// seq_array_divider: sequential restoring divider, one quotient bit per clock.
//   clk, rst (async, active high); start, dividend[DW], divisor[VW] in;
//   busy, done (1-cycle pulse), quotient[DW], remainder[VW], div_by_zero out.
//   Define DIV_ZERO_DETECT_EN to finish zero-divisor ops in one cycle and flag them.
module seq_array_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);
  localparam int CW = $clog2(DW + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [DW-1:0] sh;
  logic [VW-1:0] dv;
  logic [VW:0] r, rs, rn;
  logic [CW-1:0] cnt;
  logic ge, zero, fin, dz;
`ifdef DIV_ZERO_DETECT_EN
  assign zero = dv == '0;
`else
  assign zero = 1'b0;
`endif
  // shift the next dividend bit into the partial remainder, subtract when it fits
  assign rs = {r[VW-1:0], sh[DW-1]};
  assign ge = rs >= {1'b0, dv};
  assign rn = ge ? rs - {1'b0, dv} : rs;
  assign fin = state == RUN && (cnt == CW'(1) || zero);
  assign busy = state == RUN;
  assign done = state == DONE;
  assign div_by_zero = dz;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? RUN : IDLE;
      RUN:     state_nx = fin ? DONE : RUN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh <= '0;
      dv <= '0;
      r <= '0;
      cnt <= '0;
      quotient <= '0;
      remainder <= '0;
      dz <= 1'b0;
    end else if (state == IDLE && start) begin
      sh <= dividend;
      dv <= divisor;
      r <= '0;
      cnt <= CW'(DW);
    end else if (state == RUN) begin
      sh <= {sh[DW-2:0], ge};
      r <= rn;
      cnt <= cnt - CW'(1);
      if (fin) begin
        quotient <= zero ? '1 : {sh[DW-2:0], ge};
        remainder <= zero ? '0 : rn[VW-1:0];
        dz <= zero;
      end
    end
endmodule

// File: tb/tb_seq_array_divider.sv
// tb_seq_array_divider: directed self-checking bench for seq_array_divider
module tb_seq_array_divider;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] dividend = '0, quotient;
  logic [3:0] divisor = '0, remainder;
  logic busy, done, div_by_zero;
  int n_chk = 0, n_fail = 0, n_done = 0, nd0;
  logic [7:0] pq = '0;
  logic [3:0] pr = '0;
  seq_array_divider #(.DW(8), .VW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done) n_done++;
  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic ck(input string t, input logic ok, input int o, input int e);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", t, o, e);
    end
  endtask
  task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] eq, input logic [3:0] er, input logic edz, input int elat);
    int lat = 0, bc = 0;
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dividend = ~a; divisor = ~b;
    ck({tag, "_hold_q"}, quotient === pq, quotient, pq);
    ck({tag, "_hold_r"}, remainder === pr, remainder, pr);
    while (!done && lat < 40) begin
      bc += int'(busy);
      @(negedge clk);
      lat++;
    end
    ck({tag, "_lat"}, lat === elat, lat, elat);
    ck({tag, "_busy_cycles"}, bc === elat, bc, elat);
    ck({tag, "_busy_at_done"}, busy === 1'b0, busy, 0);
    ck({tag, "_q"}, quotient === eq, quotient, eq);
    ck({tag, "_r"}, remainder === er, remainder, er);
    ck({tag, "_dz"}, div_by_zero === edz, div_by_zero, edz);
    @(negedge clk);
    ck({tag, "_done_1cyc"}, done === 1'b0, done, 0);
    ck({tag, "_q_held"}, quotient === eq, quotient, eq);
    pq = eq; pr = er;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    ck("rst_busy", busy === 1'b0, busy, 0);
    ck("rst_done", done === 1'b0, done, 0);
    ck("rst_q", quotient === 8'd0, quotient, 0);
    ck("rst_r", remainder === 4'd0, remainder, 0);
    ck("rst_dz", div_by_zero === 1'b0, div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);
    run_op("d143_11", 8'd143, 4'd11, 8'd13, 4'd0, 1'b0, 8);
    run_op("d200_7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8);
    run_op("d255_1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 8);
    run_op("d0_5", 8'd0, 4'd5, 8'd0, 4'd0, 1'b0, 8);
    for (int a = 1; a <= 15; a++)
      for (int b = 1; b <= 15; b++) begin
        run_op("rt_by_b", 8'(a * b), 4'(b), 8'(a), 4'd0, 1'b0, 8);
        run_op("rt_by_a", 8'(a * b), 4'(a), 8'(b), 4'd0, 1'b0, 8);
      end
    nd0 = n_done;
    dividend = 8'd143; divisor = 4'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    dividend = 8'd50; divisor = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    ck("midrun_done", done === 1'b1, done, 1);
    ck("midrun_q", quotient === 8'd13, quotient, 13);
    ck("midrun_r", remainder === 4'd0, remainder, 0);
    repeat (20) @(negedge clk);
    ck("midrun_one_done", n_done - nd0 === 1, n_done - nd0, 1);
    dividend = 8'd100; divisor = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    ck("abort_busy", busy === 1'b0, busy, 0);
    ck("abort_done", done === 1'b0, done, 0);
    ck("abort_q", quotient === 8'd0, quotient, 0);
    ck("abort_r", remainder === 4'd0, remainder, 0);
    ck("abort_dz", div_by_zero === 1'b0, div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    nd0 = n_done;
    repeat (12) @(negedge clk);
    ck("abort_no_done", n_done - nd0 === 0, n_done - nd0, 0);
    ck("abort_idle", busy === 1'b0, busy, 0);
    pq = '0; pr = '0;
    run_op("d100_3", 8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 8);
`ifdef DIV_ZERO_DETECT_EN
    run_op("dz_a5", 8'hA5, 4'd0, 8'hFF, 4'd0, 1'b1, 1);
    ck("dz_hold", div_by_zero === 1'b1, div_by_zero, 1);
    run_op("d10_3", 8'd10, 4'd3, 8'd3, 4'd1, 1'b0, 8);
`else
    run_op("dz_a5", 8'hA5, 4'd0, 8'hFF, 4'd5, 1'b0, 8);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_array_divider.md
Name: seq_array_divider

Overview:
- Sequential restoring divider; the inverse operation of the team's 4x4 combinational array multiplier.
- Takes a DW-bit dividend (a product-width value) and a VW-bit divisor.
- Returns a DW-bit quotient and a VW-bit remainder.
- Produces one quotient bit per clock.
- Sits beside the multiplier in the part-3 arithmetic datapath; used for multiply/divide round-trip checks on the board.

Parameters:
- DW, 8, dividend and quotient width.
- VW, 4, divisor and remainder width (VW < DW).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  DW  numerator; captured on the accepting edge.
- divisor  input  VW  denominator; captured on the accepting edge.
- busy  output  1  high while a division is in progress.
- done  output  1  single-cycle completion pulse.
- quotient  output  DW  result, registered.
- remainder  output  VW  result, registered.
- div_by_zero  output  1  set when the last completed op had divisor == 0.

Behaviour:
- Reset (async, rst=1): state IDLE. busy, done, quotient, remainder and div_by_zero are all 0. Internal shift/remainder registers and counter are 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge: capture dividend into the shift register and divisor into the divisor register; partial remainder R (VW+1 bits) = 0; count = DW. Go to RUN, busy=1.
  - start=0: stay in IDLE.
- RUN, one iteration per edge:
  - R = {R[VW-1:0], msb of shift reg}; shift reg <<= 1.
  - If R >= {0,divisor}: R -= divisor, and the new quotient bit shifted into the shift-reg lsb is 1. Otherwise the new bit is 0.
  - count decrements.
  - On the edge where count goes 1 -> 0, the final results are written directly into the quotient/remainder output registers, done=1, busy=0, and the state goes to DONE.
- Latency: done is high in the cycle following the DW-th edge after the accepting edge (DW=8 -> 8 cycles).
- DONE: lasts exactly one cycle, with done=1. Then done=0 and the state returns to IDLE.
- Output stability: quotient, remainder and div_by_zero change only at completion. They hold their values through IDLE and through the next op's RUN until its completion.
- start while in RUN or DONE is ignored; there is no queuing. The earliest new accept is the first IDLE cycle after done.
- dividend/divisor changing after acceptance has no effect.
- Width rule: remainder < divisor always for divisor != 0, so it fits VW bits. The quotient fits DW bits for any divisor >= 1.
- rst asserted mid-operation aborts immediately: all state and outputs go to reset values and no done pulse is produced.
- Divisor == 0 without the macro: the algorithm runs unchanged for DW cycles. Result: quotient = all ones, remainder = dividend[VW-1:0], div_by_zero = 0.

Optional Feature:
- DIV_ZERO_DETECT_EN defined:
  - Divisor == 0 at accept skips RUN: the next edge writes quotient = all ones, remainder = 0, div_by_zero = 1, done = 1, and goes to DONE (1-cycle latency).
  - div_by_zero is cleared at the completion of any later nonzero-divisor op.
- DIV_ZERO_DETECT_EN undefined:
  - div_by_zero is tied to 0.
  - Zero divisors take the normal DW-cycle path with the result given above.

Test Plan:
- Reset, then dividend=143, divisor=11, start 1 cycle -> busy for 8 cycles, done pulse exactly 1 cycle, quotient=13, remainder=0.
- 200/7, then 255/1, then 0/5, back-to-back at the earliest legal start -> (28,4), (255,0), (0,0). Outputs hold between ops.
- Multiplier round trip: for all a,b in 1..15, divide p=a*b by b -> quotient=a, remainder=0. For divisor=a -> quotient=b.
- Start pulsed mid-RUN with different operands -> ignored: 9 cycles after the first accept, one done with the original result and no second done.
- rst raised at cycle 4 of 100/3 -> all outputs 0 immediately, no done. A new 100/3 afterwards -> 33 r1.
- Divisor=0, dividend=0xA5:
  - With DIV_ZERO_DETECT_EN: done after 1 cycle, quotient=0xFF, remainder=0, div_by_zero=1. A following 10/3 -> 3 r1, div_by_zero=0.
  - Without the macro: done after 8 cycles, quotient=0xFF, remainder=5, div_by_zero=0.
